// File: rtl/tortoise_pkg.sv
// Shared front-end types: fetch entry layout plus instruction fetch queue sizing.
package tortoise_pkg;

    localparam int INSTR_PER_FETCH = 2;
    localparam int IFQ_DEPTH       = 8;
    localparam int IFQ_PUSH_W      = INSTR_PER_FETCH;
    localparam int IFQ_POP_W       = 2;
    localparam int IFQ_POP_CNT_W   = $clog2(IFQ_POP_W + 1);

    typedef logic [$clog2(IFQ_DEPTH)-1:0]   ifq_ptr_t;
    typedef logic [$clog2(IFQ_DEPTH+1)-1:0] ifq_cnt_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } exception_t;

    typedef struct packed {
        logic        is_taken;
        logic [31:0] target;
    } branch_predict_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        logic [31:0]     instr;
        exception_t      ex;
        branch_predict_t predict;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_lane_compact.sv
// Turns a fetch-group lane mask into kept lanes, packed write offsets and a write count.
module fetch_lane_compact
    import tortoise_pkg::*;
(
    input  logic     [IFQ_PUSH_W-1:0] lane_valid_i,
    input  logic     [IFQ_PUSH_W-1:0] lane_stop_i,
    output logic     [IFQ_PUSH_W-1:0] keep_o,
    output ifq_ptr_t [IFQ_PUSH_W-1:0] offset_o,
    output ifq_cnt_t                  n_written_o
);

    ifq_cnt_t cnt;
    logic     stop;

    // A kept lane that faults or is predicted taken ends the group; younger lanes are wrong-path.
    always_comb begin
        keep_o   = '0;
        offset_o = '0;
        cnt      = '0;
        stop     = 1'b0;
        for (int i = 0; i < IFQ_PUSH_W; i++) begin
            offset_o[i] = ifq_ptr_t'(cnt);
            if (lane_valid_i[i] && !stop) begin
                keep_o[i] = 1'b1;
                cnt       = cnt + ifq_cnt_t'(1);
                if (lane_stop_i[i]) stop = 1'b1;
            end
        end
        n_written_o = cnt;
    end

endmodule

// File: rtl/fetch_queue_mp.sv
// Multi-port instruction fetch queue: compacted multi-lane push, in-order multi-entry pop, flush.
module fetch_queue_mp
    import tortoise_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic         [IFQ_PUSH_W-1:0]      push_valid_i,
    input  fetch_entry_t [IFQ_PUSH_W-1:0]      push_entry_i,
    output logic                               push_ready_o,
    output logic         [IFQ_POP_W-1:0]       pop_valid_o,
    output fetch_entry_t [IFQ_POP_W-1:0]       pop_entry_o,
    input  logic         [IFQ_POP_CNT_W-1:0]   pop_cnt_i,
    output ifq_cnt_t                           count_o
);

    localparam ifq_cnt_t DEPTH_C  = ifq_cnt_t'(IFQ_DEPTH);
    localparam ifq_cnt_t PUSH_W_C = ifq_cnt_t'(IFQ_PUSH_W);
    localparam ifq_cnt_t POP_W_C  = ifq_cnt_t'(IFQ_POP_W);

    fetch_entry_t mem [IFQ_DEPTH];
    ifq_ptr_t     rd_ptr, wr_ptr;
    ifq_cnt_t     count;

    logic         [IFQ_PUSH_W-1:0] lane_stop;
    logic         [IFQ_PUSH_W-1:0] keep;
    ifq_ptr_t     [IFQ_PUSH_W-1:0] offset;
    fetch_entry_t [IFQ_PUSH_W-1:0] wr_entry;
    ifq_cnt_t                      n_written;
    logic                          push_fire;
    ifq_cnt_t                      push_add, pop_req, pop_eff;

    always_comb begin
        for (int i = 0; i < IFQ_PUSH_W; i++) begin
            lane_stop[i]      = push_entry_i[i].ex.valid || push_entry_i[i].predict.is_taken;
            wr_entry[i]       = push_entry_i[i];
            wr_entry[i].valid = 1'b1;
        end
    end

    fetch_lane_compact u_compact (
        .lane_valid_i (push_valid_i),
        .lane_stop_i  (lane_stop),
        .keep_o       (keep),
        .offset_o     (offset),
        .n_written_o  (n_written)
    );

    // Handshake: a group is accepted on a cycle with push_ready_o && |push_valid_i (upstream
    // holds it otherwise); ready looks only at the registered count, never at this cycle's pop.
    assign push_ready_o = (DEPTH_C - count) >= PUSH_W_C;
    assign push_fire    = push_ready_o && (|push_valid_i);
    assign push_add     = push_fire ? n_written : '0;

    // Over-large pop requests are capped at the port width, then at the occupancy.
    always_comb begin
        pop_req = ifq_cnt_t'(pop_cnt_i);
        if (pop_req > POP_W_C) pop_req = POP_W_C;
        pop_eff = (pop_req > count) ? count : pop_req;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (ifq_cnt_t'(pop_cnt_i) <= count && ifq_cnt_t'(pop_cnt_i) <= POP_W_C);
            rd_ptr <= rd_ptr + ifq_ptr_t'(pop_eff);
            wr_ptr <= wr_ptr + ifq_ptr_t'(push_add);
            count  <= count + push_add - pop_eff;
        end
    end

    // Storage has no reset; validity comes entirely from count.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_fire) begin
            for (int i = 0; i < IFQ_PUSH_W; i++) begin
                if (keep[i]) mem[wr_ptr + offset[i]] <= wr_entry[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < IFQ_POP_W; k++) begin
            pop_valid_o[k] = count > ifq_cnt_t'(k);
            pop_entry_o[k] = mem[rd_ptr + ifq_ptr_t'(k)];
        end
    end

    assign count_o = count;

endmodule
